// File: rtl/lii_out_arbiter.sv
// Round-robin arbiter sharing one LII output channel between N requester streams.
// Bounded bursts per grant, one registered output stage toward the phy.
//
// state | meaning
// IDLE  | no grant held; arbitrate among valid requesters starting after last
// GRANT | forward beats from grant_idx until burst limit or its valid drops
module lii_out_arbiter #(
  parameter int N         = 4,
  parameter int PW        = 128,
  parameter int MAX_BURST = 16,
  localparam int IW       = (N > 1) ? $clog2(N) : 1,
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic [N*PW-1:0]   req_tdata,
  input  logic [N-1:0]      req_tvalid,
  output logic [N-1:0]      req_tready,
  input  logic [N*8-1:0]    req_src,
  input  logic [N*8-1:0]    req_dst,
  output logic [PW-1:0]     lii_out_p0_tdata,
  output logic              lii_out_p0_tvalid,
  input  logic              lii_out_p0_tready,
  output logic [7:0]        lii_out_p0_src,
  output logic [7:0]        lii_out_p0_dst,
  output logic [IW-1:0]     grant_idx,
  output logic              busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   grant_idx_nxt, last, last_nxt, pick;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            any_valid, sel_valid, stage_free, accept;
  logic [PW-1:0]   sel_data;
  logic [7:0]      sel_src, sel_dst;
  logic [2*N-1:0]  dbl_valid;
  logic [N-1:0]    rot_valid;

  assign busy = (state == GRANT);

  always_comb begin
    sel_data  = '0;
    sel_src   = '0;
    sel_dst   = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_data  = req_tdata[i*PW +: PW];
        sel_src   = req_src[i*8 +: 8];
        sel_dst   = req_dst[i*8 +: 8];
        sel_valid = req_tvalid[i];
      end
    end
  end

  // Bit k of rot_valid is requester (last+1+k) mod N, so the lowest set bit wins.
  always_comb begin
    dbl_valid = {req_tvalid, req_tvalid};
    rot_valid = N'(dbl_valid >> (int'(last) + 1));
    pick      = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_valid && rot_valid[k]) begin
        any_valid = 1'b1;
        pick      = IW'((int'(last) + 1 + k) % N);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_idx_nxt = grant_idx;
    last_nxt      = last;
    cnt_nxt       = cnt;
    req_tready    = '0;
    accept        = 1'b0;
    stage_free    = !lii_out_p0_tvalid || lii_out_p0_tready;
    case (state)
      IDLE: begin
        if (any_valid) begin
          grant_idx_nxt = pick;
          cnt_nxt       = '0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        for (int i = 0; i < N; i++) begin
          if (grant_idx == IW'(i)) req_tready[i] = stage_free;
        end
        accept = sel_valid && stage_free;
        if (accept) begin
          if (cnt == CW'(MAX_BURST - 1)) begin
            state_nxt = IDLE;
            last_nxt  = grant_idx;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (!sel_valid) begin
          state_nxt = IDLE;
          last_nxt  = grant_idx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state             <= IDLE;
      grant_idx         <= '0;
      last              <= IW'(N - 1);
      cnt               <= '0;
      lii_out_p0_tvalid <= 1'b0;
      lii_out_p0_tdata  <= '0;
      lii_out_p0_src    <= '0;
      lii_out_p0_dst    <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_idx_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      if (accept) begin
        lii_out_p0_tvalid <= 1'b1;
        lii_out_p0_tdata  <= sel_data;
        lii_out_p0_src    <= sel_src;
        lii_out_p0_dst    <= sel_dst;
      end else if (lii_out_p0_tready) begin
        lii_out_p0_tvalid <= 1'b0;
      end
    end
  end

endmodule
